// File: rtl/coreuart_pkg.sv
// Shared constants and types for the UART core.
// Receive FIFO entries are packed as {perr, data[7:0]}.
package coreuart_pkg;

   localparam int RX_FIFO_DEPTH_DEFAULT = 16;
   localparam int RX_FIFO_AFULL_DEFAULT = 12;
   localparam int RX_ENTRY_W            = 9;

   typedef struct packed {
      logic       perr;
      logic [7:0] data;
   } rx_entry_t;

   function automatic rx_entry_t pack_rx_entry(input logic [7:0] data, input logic perr);
      rx_entry_t e;
      e.perr = perr;
      e.data = data;
      return e;
   endfunction

endpackage

// File: rtl/rx_fifo_mem.sv
// Receive FIFO storage: one synchronous write port and one asynchronous read port.
// Contents are never reset, so this maps onto distributed RAM.
module rx_fifo_mem
   import coreuart_pkg::*;
#(
   parameter int DEPTH = RX_FIFO_DEPTH_DEFAULT,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [RX_ENTRY_W-1:0] wdata,
   input  logic [AW-1:0]         raddr,
   output logic [RX_ENTRY_W-1:0] rdata
);

   logic [RX_ENTRY_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/rx_fifo_ctrl.sv
// Receive FIFO behind the UART receiver: captures characters on the active-low
// write strobe and presents them show-ahead to the register interface.
module rx_fifo_ctrl
   import coreuart_pkg::*;
#(
   parameter int DEPTH       = RX_FIFO_DEPTH_DEFAULT,
   parameter int AFULL_LEVEL = RX_FIFO_AFULL_DEFAULT
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     fifo_write_n,
   input  logic [7:0]               rx_byte_in,
   input  logic                     parity_err_in,
   input  logic                     read_rx_byte,
   output logic [7:0]               rx_data,
   output logic                     rx_data_perr,
   output logic                     data_ready,
   output logic                     rx_full,
   output logic                     rx_afull,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   rx_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LEVEL);

   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          overflow_q;

   logic          wr_req, wr_acc, rd_acc, drop;
   rx_entry_t     wr_entry, head;

   // A read only counts when there is something to pop; a write into a full
   // FIFO survives only if a read frees a slot in the same cycle.
   assign rd_acc = read_rx_byte && (count != '0);
   assign wr_req = !fifo_write_n;
   assign wr_acc = wr_req && ((count != DEPTH_C) || rd_acc);
   assign drop   = wr_req && !wr_acc;

   assign wr_entry = pack_rx_entry(rx_byte_in, parity_err_in);

   rx_fifo_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (wr_acc && reset_n),
      .waddr (wr_ptr),
      .wdata (wr_entry),
      .raddr (rd_ptr),
      .rdata (head)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (wr_acc)
            wr_ptr <= wr_ptr + AW'(1);
         if (rd_acc)
            rd_ptr <= rd_ptr + AW'(1);
         if (wr_acc && !rd_acc)
            count <= count + CW'(1);
         else if (rd_acc && !wr_acc)
            count <= count - CW'(1);
         // Drop takes priority over the read-side clear.
         if (drop)
            overflow_q <= 1'b1;
         else if (read_rx_byte)
            overflow_q <= 1'b0;
      end
   end

   assign rx_data      = head.data;
   assign rx_data_perr = head.perr;
   assign data_ready   = (count != '0);
   assign rx_full      = (count == DEPTH_C);
   assign rx_afull     = (count >= AFULL_C);
   assign overflow     = overflow_q;
   assign rx_count     = count;

endmodule
